sop_eval_pipe: RTL and testbench

//  Programmable, pipelined two-level AND-OR (sum-of-products) evaluator for logic-synthesis regression benches.
//  N_TERMS product terms (cubes) are ANDed over N_IN inputs. Each term is then ORed into any subset of N_OUT outputs.

---
 rtl/sop_pkg.sv | 20 ++
 rtl/sop_term_bank.sv | 43 ++++
 rtl/sop_eval_pipe.sv | 92 +++++++++
 tb/tb_sop_eval_pipe.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sop_pkg.sv
// Shared types and helpers for the sum-of-products evaluator.
package sop_pkg;

   localparam int unsigned MAX_IN    = 64;
   localparam int unsigned MAX_TERMS = 32;
   localparam int unsigned MAX_OUT   = 8;

   typedef struct packed {
      logic               en;
      logic [MAX_IN-1:0]  pos;
      logic [MAX_IN-1:0]  neg;
      logic [MAX_OUT-1:0] or_mask;
   } cube_t;

   // Unused upper literal bits are zero, so they never constrain the cube.
   function automatic logic cube_eval(input cube_t c, input logic [MAX_IN-1:0] x);
      return c.en & (&(~c.pos | x)) & (&(~c.neg | ~x));
   endfunction

endpackage

// File: rtl/sop_term_bank.sv
// Cube storage, run-time write port and the combinational AND-plane.
module sop_term_bank
   import sop_pkg::*;
#(
   parameter int unsigned N_IN    = 12,
   parameter int unsigned N_TERMS = 8,
   parameter int unsigned N_OUT   = 1
)(
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             wr,
   input  logic [$clog2(N_TERMS)-1:0]       addr,
   input  logic                             en,
   input  logic [N_IN-1:0]                  pos,
   input  logic [N_IN-1:0]                  neg,
   input  logic [N_OUT-1:0]                 orm,
   input  logic [N_IN-1:0]                  x,
   output logic [N_TERMS-1:0]               t,
   output logic [N_OUT-1:0][N_TERMS-1:0]    or_col
);

   localparam int unsigned AW = $clog2(N_TERMS);

   cube_t cubes [N_TERMS];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned k = 0; k < N_TERMS; k++) cubes[k] <= '0;
      end else if (wr && ({1'b0, addr} < (AW+1)'(N_TERMS))) begin
         cubes[addr] <= '{en: en, pos: MAX_IN'(pos), neg: MAX_IN'(neg), or_mask: MAX_OUT'(orm)};
      end
   end

   always_comb begin
      t      = '0;
      or_col = '0;
      for (int unsigned k = 0; k < N_TERMS; k++) begin
         t[k] = cube_eval(cubes[k], MAX_IN'(x));
         for (int unsigned j = 0; j < N_OUT; j++) or_col[j][k] = cubes[k].or_mask[j];
      end
   end

endmodule

// File: rtl/sop_eval_pipe.sv
// Two-stage pipelined AND-OR evaluator with valid/ready streaming and idle-only config writes.
module sop_eval_pipe
   import sop_pkg::*;
#(
   parameter int unsigned N_IN    = 12,
   parameter int unsigned N_TERMS = 8,
   parameter int unsigned N_OUT   = 1,
   parameter int unsigned CNT_W   = 16
)(
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          cfg_we,
   input  logic [$clog2(N_TERMS)-1:0]    cfg_addr,
   input  logic                          cfg_en,
   input  logic [N_IN-1:0]               cfg_pos,
   input  logic [N_IN-1:0]               cfg_neg,
   input  logic [N_OUT-1:0]              cfg_or,
   output logic                          cfg_ready,
   output logic                          cfg_err,
   input  logic                          in_valid,
   input  logic [N_IN-1:0]               in_data,
   output logic                          in_ready,
   output logic                          out_valid,
   output logic [N_OUT-1:0]              out_data,
   input  logic                          out_ready,
   output logic [CNT_W-1:0]              txn_cnt
);

   logic                          s1_valid;
   logic [N_TERMS-1:0]            s1_t;
   logic [N_TERMS-1:0]            t;
   logic [N_OUT-1:0][N_TERMS-1:0] or_col;
   logic [N_OUT-1:0]              or_plane;
   logic                          adv1, adv2, cfg_wr, in_fire;

   // Config only lands while nothing is in flight and no vector competes.
   always_comb begin
      adv2      = ~out_valid | out_ready;
      adv1      = ~s1_valid | adv2;
      cfg_ready = ~s1_valid & ~out_valid & ~in_valid & ~rst;
      cfg_wr    = cfg_we & cfg_ready;
      in_ready  = adv1 & ~cfg_wr & ~rst;
      in_fire   = in_valid & in_ready;
   end

   sop_term_bank #(
      .N_IN    (N_IN),
      .N_TERMS (N_TERMS),
      .N_OUT   (N_OUT)
   ) u_bank (
      .clk    (clk),
      .rst    (rst),
      .wr     (cfg_wr),
      .addr   (cfg_addr),
      .en     (cfg_en),
      .pos    (cfg_pos),
      .neg    (cfg_neg),
      .orm    (cfg_or),
      .x      (in_data),
      .t      (t),
      .or_col (or_col)
   );

   always_comb begin
      or_plane = '0;
      for (int unsigned j = 0; j < N_OUT; j++) or_plane[j] = |(s1_t & or_col[j]);
   end

   // S1 holds term hits, S2 holds the OR-plane result; each stage moves only when it may.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         s1_t      <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         cfg_err   <= 1'b0;
         txn_cnt   <= '0;
      end else begin
         if (adv1) begin
            s1_valid <= in_fire;
            if (in_fire) s1_t <= t;
         end
         if (adv2) begin
            out_valid <= s1_valid;
            if (s1_valid) out_data <= or_plane;
         end
         cfg_err <= cfg_we & ~cfg_ready;
         if (out_valid & out_ready) txn_cnt <= txn_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_sop_eval_pipe.sv
// Scoreboard bench for sop_eval_pipe against a literal-by-literal SOP reference model.
module tb_sop_eval_pipe;

   localparam int unsigned N_IN    = 12;
   localparam int unsigned N_TERMS = 8;
   localparam int unsigned N_OUT   = 2;
   localparam int unsigned CNT_W   = 4;
   localparam int unsigned AW      = 3;

   logic               clk;
   logic               rst;
   logic               cfg_we;
   logic [AW-1:0]      cfg_addr;
   logic               cfg_en;
   logic [N_IN-1:0]    cfg_pos, cfg_neg;
   logic [N_OUT-1:0]   cfg_or;
   logic               cfg_ready, cfg_err;
   logic               in_valid;
   logic [N_IN-1:0]    in_data;
   logic               in_ready;
   logic               out_valid;
   logic [N_OUT-1:0]   out_data;
   logic               out_ready;
   logic [CNT_W-1:0]   txn_cnt;

   sop_eval_pipe #(.N_IN(N_IN), .N_TERMS(N_TERMS), .N_OUT(N_OUT), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_en(cfg_en), .cfg_pos(cfg_pos),
      .cfg_neg(cfg_neg), .cfg_or(cfg_or), .cfg_ready(cfg_ready), .cfg_err(cfg_err),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .txn_cnt(txn_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state
   logic             m_en  [N_TERMS];
   logic [N_IN-1:0]  m_pos [N_TERMS];
   logic [N_IN-1:0]  m_neg [N_TERMS];
   logic [N_OUT-1:0] m_or  [N_TERMS];

   logic [N_OUT-1:0] exp_q[$];
   int               hs_cyc[$];
   int               cyc = 0;
   int               exp_cnt = 0;
   int               tests = 0;
   int               errors = 0;
   bit               rnd_ready = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // An output is 1 if some enabled term feeding it has every one of its literals satisfied.
   function automatic logic [N_OUT-1:0] ref_eval(input logic [N_IN-1:0] x);
      logic [N_OUT-1:0] r = '0;
      for (int j = 0; j < N_OUT; j++)
         for (int k = 0; k < N_TERMS; k++)
            if (m_en[k] && m_or[k][j]) begin
               bit hit = 1;
               for (int i = 0; i < N_IN; i++) begin
                  if (m_pos[k][i] && !x[i]) hit = 0;
                  if (m_neg[k][i] &&  x[i]) hit = 0;
               end
               if (hit) r[j] = 1'b1;
            end
      return r;
   endfunction

   // Monitor: pops and compares on every presented result.
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
               tests++;
               errors++;
               $display("FAIL unexpected_out: got out_valid=1 data=%0h expected no result", out_data);
            end else begin
               check("out_data", 64'(out_data), 64'(exp_q[0]));
               if (out_ready) begin
                  check("txn_cnt_pre", 64'(txn_cnt), 64'(exp_cnt));
                  void'(exp_q.pop_front());
                  exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
                  hs_cyc.push_back(cyc);
               end
            end
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [N_IN-1:0] x);
      int n = 0;
      bit acc = 0;
      in_valid = 1'b1;
      in_data  = x;
      while (!acc && n < 200) begin
         @(negedge clk);
         acc = in_ready;
         tick();
         n++;
      end
      in_valid = 1'b0;
      if (acc) exp_q.push_back(ref_eval(x));
      else check("send_timeout", 64'(0), 64'(1));
   endtask

   task automatic cfg_write(input int k, input logic en, input logic [N_IN-1:0] pos,
                            input logic [N_IN-1:0] neg, input logic [N_OUT-1:0] orm,
                            input logic exp_ok);
      logic ok;
      cfg_we = 1'b1; cfg_addr = AW'(k); cfg_en = en;
      cfg_pos = pos; cfg_neg = neg; cfg_or = orm;
      @(negedge clk);
      ok = cfg_ready;
      tick();
      cfg_we = 1'b0;
      check("cfg_ready", 64'(ok), 64'(exp_ok));
      if (ok) begin
         m_en[k] = en; m_pos[k] = pos; m_neg[k] = neg; m_or[k] = orm;
      end
      @(negedge clk);
      check("cfg_err", 64'(cfg_err), 64'(!ok));
      tick();
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (n >= 500) check("idle_timeout", 64'(0), 64'(1));
      tick();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      exp_q.delete();
      exp_cnt = 0;
      for (int k = 0; k < N_TERMS; k++) begin
         m_en[k] = 0; m_pos[k] = '0; m_neg[k] = '0; m_or[k] = '0;
      end
      @(negedge clk);
      check("rst_in_ready", 64'(in_ready), 64'(0));
      check("rst_cfg_ready", 64'(cfg_ready), 64'(0));
      tick();
      @(negedge clk);
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_out_data", 64'(out_data), 64'(0));
      check("rst_txn_cnt", 64'(txn_cnt), 64'(0));
      check("rst_cfg_err", 64'(cfg_err), 64'(0));
      tick();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; cfg_we = 0; cfg_addr = '0; cfg_en = 0; cfg_pos = '0; cfg_neg = '0;
      cfg_or = '0; in_valid = 0; in_data = '0; out_ready = 1'b1;
      tick();

      // T1: reset, then all-ones vector through an all-disabled bank
      do_reset();
      send(12'hFFF);
      @(negedge clk);
      check("t1_lat1_valid", 64'(out_valid), 64'(0));
      tick();
      @(negedge clk);
      check("t1_lat2_valid", 64'(out_valid), 64'(1));
      check("t1_data", 64'(out_data), 64'(0));
      tick();
      wait_idle();

      // T2: basic SOP, back-to-back
      do_reset();
      cfg_write(0, 1, 12'h003, 12'h000, 2'b01, 1);
      cfg_write(1, 1, 12'hC00, 12'h000, 2'b01, 1);
      cfg_write(2, 1, 12'h008, 12'h010, 2'b01, 1);
      hs_cyc.delete();
      send(12'h003); send(12'hC00); send(12'h008); send(12'h018); send(12'h000);
      wait_idle();
      check("t2_hs_count", 64'(hs_cyc.size()), 64'(5));
      if (hs_cyc.size() == 5) check("t2_no_bubble", 64'(hs_cyc[4] - hs_cyc[0]), 64'(4));
      check("t2_txn_cnt", 64'(txn_cnt), 64'(5));

      // T3: contradictory cube and empty cube
      do_reset();
      cfg_write(0, 1, 12'h004, 12'h004, 2'b01, 1);
      cfg_write(1, 1, 12'h000, 12'h000, 2'b01, 1);
      for (int i = 0; i < 4; i++) send(N_IN'($urandom));
      wait_idle();
      cfg_write(1, 0, 12'h000, 12'h000, 2'b01, 1);
      for (int i = 0; i < 4; i++) send(N_IN'($urandom));
      wait_idle();

      // T4: backpressure
      out_ready = 1'b0;
      send(12'h111);
      send(12'h222);
      fork
         send(12'h333);
         begin
            repeat (4) begin
               @(negedge clk);
               check("t4_in_ready_low", 64'(in_ready), 64'(0));
            end
            tick();
            out_ready = 1'b1;
         end
      join
      wait_idle();

      // T5: refused config write while S1 is busy
      send(12'h020);
      cfg_write(3, 1, 12'h020, 12'h000, 2'b10, 0);
      wait_idle();
      send(12'h020);
      wait_idle();
      cfg_write(3, 1, 12'h020, 12'h000, 2'b10, 1);
      send(12'h020);
      wait_idle();

      // Randomised config and traffic with random backpressure
      for (int k = 0; k < N_TERMS; k++)
         cfg_write(k, 1'($urandom_range(0, 3) != 0), N_IN'($urandom & $urandom & $urandom),
                   N_IN'($urandom & $urandom & $urandom & $urandom), N_OUT'($urandom), 1);
      rnd_ready = 1;
      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 3) == 0) tick();
         send(N_IN'($urandom));
      end
      rnd_ready = 0;
      out_ready = 1'b1;
      wait_idle();

      // T6: counter wrap, then reset with vectors in flight
      do_reset();
      for (int i = 0; i < 17; i++) send(N_IN'($urandom));
      wait_idle();
      check("t6_wrap", 64'(txn_cnt), 64'(1));
      out_ready = 1'b0;
      send(12'hABC);
      send(12'h123);
      do_reset();
      out_ready = 1'b1;
      repeat (6) begin
         @(negedge clk);
         check("t6_flush", 64'(out_valid), 64'(0));
      end

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
